// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph table, segment bit order and slot-index width helper
package seg_pkg;

   // Segment positions inside the 8-bit {a,b,c,d,e,f,g,dp} output byte
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   // Hex glyphs 0..F, active-high, dp bit clear
   localparam logic [7:0] GLYPHS [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   // Width of the slot index; never narrower than one bit
   function automatic int slot_width(input int n_digits);
      return (n_digits <= 2) ? 1 : $clog2(n_digits);
   endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// rtl/seg_display_mux_if.sv - valid/ready load channel for the display shadow data
interface seg_display_mux_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] i_data;
   logic [N_DIGITS-1:0]   i_dp;
   logic                  i_valid;
   logic                  o_ready;

   modport master (output i_data, output i_dp, output i_valid, input o_ready);
   modport slave  (input i_data, input i_dp, input i_valid, output o_ready);
endinterface

// File: rtl/seg_hex_decoder.sv
// rtl/seg_hex_decoder.sv - combinational nibble to seven-segment map, dp excluded
module seg_hex_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   logic [7:0] glyph;

   assign glyph = GLYPHS[nibble_i];
   assign seg_o = glyph[SEG_A:SEG_G];

endmodule

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - multiplexed N-digit 7-segment driver with frame-aligned loads
module seg_display_mux
   import seg_pkg::*;
#(
   parameter int N_DIGITS   = 4,
   parameter int CNT_WIDTH  = 14,
   parameter int PWM_BITS   = 4,
   parameter int BLINK_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg_display_mux_if.slave      load_if,
   input  logic                  i_lz_blank,
   input  logic [PWM_BITS-1:0]   i_bright,
   input  logic [N_DIGITS-1:0]   i_blink,
   output logic [N_DIGITS-1:0]   o_anodes,
   output logic [7:0]            o_segments,
   output logic                  o_frame
);

   localparam int               POS_W    = slot_width(N_DIGITS);
   localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_DIGITS - 1);

   logic [CNT_WIDTH-1:0]       pre_q, pre_d;
   logic [POS_W-1:0]           pos_q, pos_d;
   logic [BLINK_BITS-1:0]      frame_cnt_q, frame_cnt_d;
   logic [N_DIGITS-1:0][3:0]   pend_data_q, pend_data_d;
   logic [N_DIGITS-1:0]        pend_dp_q, pend_dp_d;
   logic                       pend_full_q, pend_full_d;
   logic [N_DIGITS-1:0][3:0]   shadow_data_q, shadow_data_d;
   logic [N_DIGITS-1:0]        shadow_dp_q, shadow_dp_d;
   logic [N_DIGITS-1:0]        anodes_q, anodes_d;
   logic [7:0]                 segments_q, segments_d;
   logic                       frame_q, frame_d;

   logic                       wrap;
   logic                       boundary;
   logic                       accept;
   logic [N_DIGITS-1:0]        lead_zero;
   logic                       zero_run;
   logic                       blank;
   logic [3:0]                 cur_nibble;
   logic [6:0]                 cur_seg7;

   assign wrap            = &pre_q;
   assign boundary        = wrap && (pos_q == LAST_POS);
   assign accept          = load_if.i_valid && !pend_full_q;
   assign load_if.o_ready = !pend_full_q;
   assign cur_nibble      = shadow_data_q[pos_q];

   seg_hex_decoder u_dec (
      .nibble_i (cur_nibble),
      .seg_o    (cur_seg7)
   );

   // Prescaler, slot index and frame counter advance
   always_comb begin
      pre_d       = pre_q + CNT_WIDTH'(1);
      pos_d       = pos_q;
      frame_cnt_d = frame_cnt_q;
      if (wrap) begin
         pos_d = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
      end
      if (boundary) begin
         frame_cnt_d = frame_cnt_q + BLINK_BITS'(1);
      end
   end

   // Pending capture on handshake; pending moves to shadow only at a frame boundary
   always_comb begin
      pend_data_d   = pend_data_q;
      pend_dp_d     = pend_dp_q;
      pend_full_d   = pend_full_q;
      shadow_data_d = shadow_data_q;
      shadow_dp_d   = shadow_dp_q;
      if (boundary && pend_full_q) begin
         shadow_data_d = pend_data_q;
         shadow_dp_d   = pend_dp_q;
         pend_full_d   = 1'b0;
      end
      if (accept) begin
         pend_data_d = load_if.i_data;
         pend_dp_d   = load_if.i_dp;
         pend_full_d = 1'b1;
      end
   end

   // Leading-zero map: bit k set when shadow nibbles k..top are all zero
   always_comb begin
      lead_zero = '0;
      zero_run  = 1'b1;
      for (int k = N_DIGITS - 1; k >= 0; k--) begin
         zero_run     = zero_run && (shadow_data_q[k] == 4'h0);
         lead_zero[k] = zero_run;
      end
   end

   // Blank decision and next registered anode/segment/frame outputs
   always_comb begin
      blank = (i_lz_blank && (pos_q != '0) && lead_zero[pos_q])
           || (i_blink[pos_q] && frame_cnt_q[BLINK_BITS-1])
           || (pre_q[CNT_WIDTH-1 -: PWM_BITS] >= i_bright);
      anodes_d   = '1;
      segments_d = 8'h00;
      frame_d    = boundary;
      if (!blank) begin
         anodes_d[pos_q] = 1'b0;
         segments_d      = {cur_seg7, shadow_dp_q[pos_q]};
      end
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q         <= '0;
         pos_q         <= '0;
         frame_cnt_q   <= '0;
         pend_data_q   <= '0;
         pend_dp_q     <= '0;
         pend_full_q   <= 1'b0;
         shadow_data_q <= '0;
         shadow_dp_q   <= '0;
         anodes_q      <= '1;
         segments_q    <= 8'h00;
         frame_q       <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         pos_q         <= pos_d;
         frame_cnt_q   <= frame_cnt_d;
         pend_data_q   <= pend_data_d;
         pend_dp_q     <= pend_dp_d;
         pend_full_q   <= pend_full_d;
         shadow_data_q <= shadow_data_d;
         shadow_dp_q   <= shadow_dp_d;
         anodes_q      <= anodes_d;
         segments_q    <= segments_d;
         frame_q       <= frame_d;
      end
   end

   assign o_anodes   = anodes_q;
   assign o_segments = segments_q;
   assign o_frame    = frame_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - directed self-checking bench for seg_display_mux
module tb_seg_display_mux;

   localparam int N_DIGITS   = 4;
   localparam int CNT_WIDTH  = 4;
   localparam int PWM_BITS   = 2;
   localparam int BLINK_BITS = 2;

   logic                  clk;
   logic                  rst_n;
   logic                  i_lz_blank;
   logic [PWM_BITS-1:0]   i_bright;
   logic [N_DIGITS-1:0]   i_blink;
   logic [N_DIGITS-1:0]   o_anodes;
   logic [7:0]            o_segments;
   logic                  o_frame;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   seg_display_mux_if #(.N_DIGITS(N_DIGITS)) lif ();

   seg_display_mux #(
      .N_DIGITS   (N_DIGITS),
      .CNT_WIDTH  (CNT_WIDTH),
      .PWM_BITS   (PWM_BITS),
      .BLINK_BITS (BLINK_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_if    (lif),
      .i_lz_blank (i_lz_blank),
      .i_bright   (i_bright),
      .i_blink    (i_blink),
      .o_anodes   (o_anodes),
      .o_segments (o_segments),
      .o_frame    (o_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_an(input string tag, input logic [3:0] exp);
      chk(tag, 32'(o_anodes), 32'(exp));
   endtask

   task automatic chk_seg(input string tag, input logic [7:0] exp);
      chk(tag, 32'(o_segments), 32'(exp));
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      chk(tag, 32'(obs), 32'(exp));
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Output for digit k, prescaler value j is visible at cyc = 1 + 16k + j
   task automatic go(input int k, input int j);
      while (cyc < 1 + 16 * k + j) step();
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_frame && n < 400);
      if (!o_frame) begin
         checks++;
         failures++;
         $display("FAIL frame_timeout observed=no_pulse expected=pulse");
      end
      cyc = 0;
   endtask

   task automatic load(input logic [15:0] data, input logic [3:0] dp);
      lif.i_data  = data;
      lif.i_dp    = dp;
      lif.i_valid = 1'b1;
      step();
      lif.i_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      lif.i_data  = '0;
      lif.i_dp    = '0;
      lif.i_valid = 1'b0;
      i_lz_blank  = 1'b0;
      i_bright    = 2'd3;
      i_blink     = 4'b0000;
      repeat (3) @(negedge clk);

      chk_an ("reset_anodes", 4'b1111);
      chk_seg("reset_segments", 8'h00);
      chk_bit("reset_ready", lif.o_ready, 1'b1);
      chk_bit("reset_frame", o_frame, 1'b0);

      rst_n = 1'b1;
      @(negedge clk);
      chk_an ("first_slot_anodes", 4'b1110);
      chk_seg("first_slot_seg", 8'hFC);

      // Anode rotation and PWM at bright=3 (lit for pre 0..11)
      wait_frame();
      go(0, 0);  chk_an("rot_d0", 4'b1110);
      go(0, 11); chk_an("pwm3_lit_end", 4'b1110);
      go(0, 12); chk_an("pwm3_dark", 4'b1111);
      go(1, 0);  chk_an("rot_d1", 4'b1101);
      go(2, 0);  chk_an("rot_d2", 4'b1011);
      go(3, 0);  chk_an("rot_d3", 4'b0111);
      while (!o_frame && cyc < 200) step();
      chk("frame_period", 32'(cyc), 32'd64);
      cyc = 0;

      // Mid-frame load, second request while busy is ignored
      go(1, 5);
      chk_bit("ready_before_load", lif.o_ready, 1'b1);
      lif.i_data  = 16'h12AF;
      lif.i_dp    = 4'b0001;
      lif.i_valid = 1'b1;
      step();
      lif.i_data  = 16'h0000;
      lif.i_dp    = 4'b1111;
      chk_bit("ready_after_load", lif.o_ready, 1'b0);
      step();
      lif.i_valid = 1'b0;
      chk_bit("ready_busy", lif.o_ready, 1'b0);
      while (cyc < 63) step();
      chk_bit("ready_busy_boundary", lif.o_ready, 1'b0);
      wait_frame();
      chk_bit("ready_after_frame", lif.o_ready, 1'b1);
      go(0, 0); chk_seg("load_d0", 8'h8F);
      go(1, 0); chk_seg("load_d1", 8'hEE);
      go(2, 0); chk_seg("load_d2", 8'hDA);
      go(3, 0); chk_seg("load_d3", 8'h60);

      // Load on the exact boundary cycle is deferred one frame
      while (cyc < 63) step();
      chk_bit("ready_at_boundary", lif.o_ready, 1'b1);
      load(16'h3456, 4'b0000);
      chk_bit("boundary_frame_pulse", o_frame, 1'b1);
      chk_bit("boundary_ready_low", lif.o_ready, 1'b0);
      cyc = 0;
      go(0, 0); chk_seg("boundary_old_d0", 8'h8F);
      wait_frame();
      go(0, 0); chk_seg("boundary_new_d0", 8'hBE);
      go(3, 0); chk_seg("boundary_new_d3", 8'hF2);

      // Leading-zero blanking
      i_lz_blank = 1'b1;
      load(16'h0030, 4'b0000);
      wait_frame();
      go(0, 0); chk_an("lz_d0_an", 4'b1110); chk_seg("lz_d0_seg", 8'hFC);
      go(1, 0); chk_an("lz_d1_an", 4'b1101); chk_seg("lz_d1_seg", 8'hF2);
      go(2, 0); chk_an("lz_d2_an", 4'b1111); chk_seg("lz_d2_seg", 8'h00);
      go(3, 0); chk_an("lz_d3_an", 4'b1111);
      load(16'h0000, 4'b0000);
      wait_frame();
      go(0, 0); chk_an("lz0_d0_an", 4'b1110); chk_seg("lz0_d0_seg", 8'hFC);
      go(1, 0); chk_an("lz0_d1_an", 4'b1111);
      go(3, 0); chk_an("lz0_d3_an", 4'b1111);
      i_lz_blank = 1'b0;
      i_bright   = 2'd1;

      // PWM brightness 1 then 0
      wait_frame();
      go(0, 3); chk_an("pwm1_lit", 4'b1110);
      go(0, 4); chk_an("pwm1_dark", 4'b1111);
      go(1, 0); chk_an("pwm1_d1", 4'b1101);
      i_bright = 2'd0;
      go(2, 0); chk_an("pwm0_d2", 4'b1111);
      go(3, 0); chk_an("pwm0_d3", 4'b1111);
      i_bright = 2'd3;

      // Reset during a pending load discards it
      go(3, 2);
      load(16'h1111, 4'b1111);
      chk_bit("pending_ready_low", lif.o_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_an ("async_reset_anodes", 4'b1111);
      chk_seg("async_reset_segments", 8'h00);
      chk_bit("async_reset_ready", lif.o_ready, 1'b1);
      @(negedge clk);
      i_blink = 4'b0100;
      rst_n   = 1'b1;
      @(negedge clk);
      chk_an ("post_reset_slot0", 4'b1110);
      chk_seg("post_reset_seg", 8'hFC);

      // Blink: frame_cnt after the f-th frame pulse is f mod 4; dark when MSB set
      wait_frame();
      go(1, 0); chk_an("blink_f1_d1", 4'b1101); chk_seg("discarded_load_d1", 8'hFC);
      go(2, 0); chk_an("blink_f1_d2", 4'b1011);
      wait_frame();
      go(1, 0); chk_an("blink_f2_d1", 4'b1101);
      go(2, 0); chk_an("blink_f2_d2", 4'b1111);
      wait_frame();
      go(2, 0); chk_an("blink_f3_d2", 4'b1111);
      go(3, 0); chk_an("blink_f3_d3", 4'b0111);
      wait_frame();
      go(2, 0); chk_an("blink_f4_d2", 4'b1011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Parametrised multiplexed 7-segment driver: the successor to the fixed 4-digit hex display. It drives N_DIGITS common-anode digits from a latched shadow register loaded through a valid/ready handshake. New data takes effect only at frame boundaries, so no digit tears. Adds per-digit decimal points, leading-zero blanking, PWM brightness and per-digit blink. It sits between the datapath (UART RX byte/status registers) and the board's anode/segment pins.

## Interface
- N_DIGITS, 4: number of digits multiplexed (≥2).
- CNT_WIDTH, 14: prescaler width; one digit slot lasts 2^CNT_WIDTH clk cycles.
- PWM_BITS, 4: brightness resolution; must be ≤ CNT_WIDTH.
- BLINK_BITS, 6: frame-counter width; blink period is 2^BLINK_BITS frames.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_data  in  4*N_DIGITS  hex nibbles; nibble k → digit k (digit 0 = rightmost).
- i_dp  in  N_DIGITS  decimal point per digit, 1 = lit.
- i_valid  in  1  load request for i_data/i_dp.
- o_ready  out  1  load accepted when i_valid & o_ready.
- i_lz_blank  in  1  enable leading-zero blanking (live, not shadowed).
- i_bright  in  PWM_BITS  brightness; 0 = dark, max = (2^PWM_BITS−1)/2^PWM_BITS duty.
- i_blink  in  N_DIGITS  per-digit blink enable (live).
- o_anodes  out  N_DIGITS  active-low digit enables.
- o_segments  out  8  active-high {a,b,c,d,e,f,g,dp}, bit 7 = a.
- o_frame  out  1  one-cycle pulse at each frame start.

## Operation
- Prescaler `pre` (CNT_WIDTH) increments every cycle. On wrap (all ones → 0), slot index `pos` advances 0→1→…→N_DIGITS−1→0.
- Frame boundary: the cycle in which `pre` wraps and `pos` = N_DIGITS−1. `frame_cnt` (BLINK_BITS) increments there.
- Handshake: in the cycle where i_valid & o_ready is true, i_data/i_dp are captured into the pending register and o_ready goes low next cycle.
- At the next frame boundary, pending is copied to the shadow register and o_ready returns high next cycle.
- A capture coinciding with a frame boundary is not applied at that boundary; it is applied at the following one.
- Digit k is displayed from shadow nibble k through the hex decoder (0–F, standard glyphs: 0 = 0xFC, 1 = 0x60, 8 = 0xFE, F = 0x8E before dp). dp bit = shadow dp[k].
- Blanking, anode off for the whole slot, when any of the following holds:
  - (a) i_lz_blank=1, k≠0, and shadow nibbles k..N_DIGITS−1 are all zero;
  - (b) i_blink[k]=1 and frame_cnt MSB=1;
  - (c) PWM off: `pre[CNT_WIDTH-1 -: PWM_BITS]` ≥ i_bright.
- Digit 0 is never blanked by (a).
- A dp set on a blanked digit is also dark.

## Timing
- o_anodes, o_segments and o_frame are registered: one cycle of latency after `pre`/`pos` change.
- o_frame is high the cycle after the frame boundary.
- Exactly one anode is low at a time; all anodes are high when the current digit is blanked.
- Reset values: o_anodes all 1; o_segments 0x00; o_frame 0; o_ready 1; pre, pos, frame_cnt, pending, shadow all 0.
- Asserting rst_n low mid-frame or mid-handshake discards the pending load immediately. The first slot after release is pos=0.
- i_bright, i_lz_blank and i_blink are sampled every cycle; changes show on the next registered output.

## Structure
- Package seg_pkg: the 16-entry glyph constants, segment bit-order constants, and the function/localparam for the slot index width ($clog2(N_DIGITS)).
- Sub-module seg_hex_decoder: combinational nibble→7-segment map (without dp), instanced once on the muxed nibble.
- The top module holds the prescaler, slot/frame counters, pending/shadow registers, handshake and blank logic.

## Test plan
- Reset, CNT_WIDTH=4, N_DIGITS=4 → o_anodes=4'b1111 and o_segments=0x00 during reset. After release, anodes cycle 1110,1101,1011,0111, 16 cycles each; o_frame pulses every 64 cycles.
- Load i_data=16'h12AF, i_dp=4'b0001 mid-frame → o_ready low until the next frame boundary. Next frame shows digit0=0x8F, digit1=0xEE, digit2=0xDA, digit3=0x60.
- Second i_valid while o_ready=0 → ignored. A load on the exact frame-boundary cycle → applied one frame later.
- i_lz_blank=1, data 16'h0030 → digits 3 and 2 anode high, digit1=0xF2, digit0=0xFC. Data 16'h0000 → only digit 0 shown.
- PWM_BITS=2, i_bright=1 → each anode low for the first 4 of 16 slot cycles. i_bright=0 → anodes never low.
- BLINK_BITS=2, i_blink=4'b0100 → digit 2 dark in frames 2–3 of every 4. Other digits are unaffected.
